// File: rtl/imem_port_arbiter.sv
// Two-port front end for a single-port synchronous instruction memory: fetch (read-only) and
// loader (read/write) share it via round-robin, with a loader lock and a saturating fetch-stall count.
module imem_port_arbiter #(
  parameter int ADDR_BITS  = 8,
  parameter int STALL_BITS = 16,
  parameter int DATA_BITS  = 32,
  parameter int INSTR_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [DATA_BITS-1:0]  f_addr,
  output logic                  f_rsp_valid,
  output logic [INSTR_BITS-1:0] f_rsp_instr,
  output logic                  f_rsp_err,
  input  logic                  l_req_valid,
  output logic                  l_req_ready,
  input  logic                  l_req_we,
  input  logic [DATA_BITS-1:0]  l_addr,
  input  logic [INSTR_BITS-1:0] l_wdata,
  input  logic                  l_lock,
  output logic                  l_rsp_valid,
  output logic [INSTR_BITS-1:0] l_rsp_rdata,
  output logic                  l_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [INSTR_BITS-1:0] mem_wdata,
  input  logic [INSTR_BITS-1:0] mem_rdata,
  output logic [STALL_BITS-1:0] f_stall_cnt
);

  typedef enum logic {SHARED = 1'b0, LOCKED = 1'b1} state_t;
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_L = 1'b1;

  state_t                r_state;
  logic                  r_rr_last;
  logic                  r_f_rsp_vld;
  logic                  r_l_rsp_vld;
  logic                  r_rsp_err;
  logic                  r_rsp_we;
  logic [STALL_BITS-1:0] r_stall;

  logic w_f_rdy, w_l_rdy, w_f_acc, w_l_acc, w_f_err, w_l_err;

  function automatic logic addr_err(input logic [DATA_BITS-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_BITS + 2)) != '0);
  endfunction

  // Readiness looks only at state, rr_last and the other side's valid; gated by reset
  // so nothing is accepted or driven to memory while reset is held.
  always_comb begin
    w_f_rdy = rst_n && (r_state == SHARED) && (!l_req_valid || (r_rr_last == OWN_L));
    w_l_rdy = rst_n && ((r_state == LOCKED) || !f_req_valid || (r_rr_last == OWN_F));
    w_f_acc = f_req_valid && w_f_rdy;
    w_l_acc = l_req_valid && w_l_rdy;
    w_f_err = addr_err(f_addr);
    w_l_err = addr_err(l_addr);
  end

  always_comb begin
    mem_en    = (w_f_acc && !w_f_err) || (w_l_acc && !w_l_err);
    mem_we    = w_l_acc && !w_l_err && l_req_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_en) mem_addr = w_l_acc ? l_addr[ADDR_BITS+1:2] : f_addr[ADDR_BITS+1:2];
    if (mem_we) mem_wdata = l_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SHARED;
      r_rr_last   <= OWN_L;
      r_f_rsp_vld <= 1'b0;
      r_l_rsp_vld <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_f_rsp_vld <= w_f_acc;
      r_l_rsp_vld <= w_l_acc;
      r_rsp_err   <= w_l_acc ? w_l_err : w_f_err;
      r_rsp_we    <= w_l_acc && l_req_we;
      if (w_f_acc)      r_rr_last <= OWN_F;
      else if (w_l_acc) r_rr_last <= OWN_L;
      case (r_state)
        SHARED: if (l_lock) r_state <= LOCKED;
        LOCKED: if (!l_lock && !w_l_acc) r_state <= SHARED;
        default: r_state <= SHARED;
      endcase
      if (f_req_valid && !w_f_rdy && (r_stall != '1)) r_stall <= r_stall + 1'b1;
    end
  end

  // Response data comes straight off the memory read port in the response cycle.
  always_comb begin
    f_req_ready = w_f_rdy;
    l_req_ready = w_l_rdy;
    f_rsp_valid = r_f_rsp_vld;
    l_rsp_valid = r_l_rsp_vld;
    f_rsp_err   = r_f_rsp_vld && r_rsp_err;
    l_rsp_err   = r_l_rsp_vld && r_rsp_err;
    f_rsp_instr = (r_f_rsp_vld && !r_rsp_err) ? mem_rdata : '0;
    l_rsp_rdata = (r_l_rsp_vld && !r_rsp_err && !r_rsp_we) ? mem_rdata : '0;
    f_stall_cnt = r_stall;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 256-word imem behind it.
module tb_imem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [31:0] f_addr, f_rsp_instr;
  logic        l_req_valid, l_req_ready, l_req_we, l_lock, l_rsp_valid, l_rsp_err;
  logic [31:0] l_addr, l_wdata, l_rsp_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] f_stall_cnt;
  logic [31:0] ram [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_instr(f_rsp_instr), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata), .l_rsp_err(l_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .f_stall_cnt(f_stall_cnt)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | 32'(i);
    mem_rdata = '0;
    rst_n = 1'b0;
    f_req_valid = 0; f_addr = '0;
    l_req_valid = 0; l_req_we = 0; l_addr = '0; l_wdata = '0; l_lock = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    chk("rst_l_rsp_valid", 32'(l_rsp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_stall", 32'(f_stall_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: single fetch, same-cycle memory strobe, response next cycle
    f_req_valid = 1; f_addr = 32'h8;
    #2;
    chk("t1_f_ready", 32'(f_req_ready), 32'd1);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd2);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    next_cyc();
    f_req_valid = 0;
    chk("t1_f_rsp_valid", 32'(f_rsp_valid), 32'd1);
    chk("t1_f_rsp_instr", f_rsp_instr, 32'hA000_0002);
    chk("t1_l_rsp_valid", 32'(l_rsp_valid), 32'd0);

    // 2: both requesting after reset -> F, L, F, L
    do_reset();
    f_req_valid = 1; f_addr = 32'h4;
    l_req_valid = 1; l_addr = 32'hC; l_req_we = 0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t2_f_ready", 32'(f_req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_l_ready", 32'(l_req_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t2_mem_addr", 32'(mem_addr), (k % 2 == 0) ? 32'd1 : 32'd3);
      next_cyc();
      chk("t2_f_rsp_valid", 32'(f_rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_l_rsp_valid", 32'(l_rsp_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("t2_f_data", f_rsp_instr, 32'hA000_0001);
      else            chk("t2_l_data", l_rsp_rdata, 32'hA000_0003);
    end
    f_req_valid = 0; l_req_valid = 0;
    chk("t2_stall", 32'(f_stall_cnt), 32'd2);

    // 3: lock for 10 cycles while fetch keeps requesting
    f_req_valid = 1; f_addr = 32'h8; l_lock = 1;
    #2;
    chk("t3_f_ready_c0", 32'(f_req_ready), 32'd1);
    next_cyc();
    chk("t3_f_rsp_c0", 32'(f_rsp_valid), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) l_lock = 0;
      #2;
      chk("t3_f_ready_lock", 32'(f_req_ready), 32'd0);
      chk("t3_l_ready_lock", 32'(l_req_ready), 32'd1);
      next_cyc();
      chk("t3_f_rsp_lock", 32'(f_rsp_valid), 32'd0);
    end
    #2;
    chk("t3_f_ready_resume", 32'(f_req_ready), 32'd1);
    chk("t3_stall", 32'(f_stall_cnt), 32'd12);
    next_cyc();
    f_req_valid = 0;
    chk("t3_f_rsp_resume", 32'(f_rsp_valid), 32'd1);
    chk("t3_f_data_resume", f_rsp_instr, 32'hA000_0002);

    // 4: address errors and the top legal word
    f_req_valid = 1; f_addr = 32'h2;
    #2;
    chk("t4_f_ready_err", 32'(f_req_ready), 32'd1);
    chk("t4_mem_en_ferr", 32'(mem_en), 32'd0);
    next_cyc();
    f_req_valid = 0;
    chk("t4_f_rsp_valid", 32'(f_rsp_valid), 32'd1);
    chk("t4_f_rsp_err", 32'(f_rsp_err), 32'd1);
    chk("t4_f_rsp_instr", f_rsp_instr, 32'd0);
    l_req_valid = 1; l_req_we = 0; l_addr = 32'h400;
    #2;
    chk("t4_l_ready_err", 32'(l_req_ready), 32'd1);
    chk("t4_mem_en_lerr", 32'(mem_en), 32'd0);
    next_cyc();
    l_req_valid = 0;
    chk("t4_l_rsp_valid", 32'(l_rsp_valid), 32'd1);
    chk("t4_l_rsp_err", 32'(l_rsp_err), 32'd1);
    chk("t4_l_rsp_rdata", l_rsp_rdata, 32'd0);
    f_req_valid = 1; f_addr = 32'h3FC;
    #2;
    chk("t4_mem_addr_top", 32'(mem_addr), 32'd255);
    next_cyc();
    f_req_valid = 0;
    chk("t4_f_err_top", 32'(f_rsp_err), 32'd0);
    chk("t4_f_data_top", f_rsp_instr, 32'hA000_00FF);

    // 5: loader write then fetch and loader reads of the same word
    l_req_valid = 1; l_req_we = 1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF;
    #2;
    chk("t5_mem_en", 32'(mem_en), 32'd1);
    chk("t5_mem_we", 32'(mem_we), 32'd1);
    chk("t5_mem_addr", 32'(mem_addr), 32'd4);
    chk("t5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cyc();
    l_req_valid = 0; l_req_we = 0;
    chk("t5_l_ack", 32'(l_rsp_valid), 32'd1);
    chk("t5_l_ack_data", l_rsp_rdata, 32'd0);
    chk("t5_l_ack_err", 32'(l_rsp_err), 32'd0);
    f_req_valid = 1; f_addr = 32'h10;
    next_cyc();
    f_req_valid = 0;
    chk("t5_f_data", f_rsp_instr, 32'hDEAD_BEEF);
    l_req_valid = 1; l_addr = 32'h10;
    next_cyc();
    l_req_valid = 0;
    chk("t5_l_data", l_rsp_rdata, 32'hDEAD_BEEF);

    // 6: reset during the accept cycle
    f_req_valid = 1; f_addr = 32'h8;
    #2;
    chk("t6_mem_en_pre", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_en_rst", 32'(mem_en), 32'd0);
    chk("t6_f_ready_rst", 32'(f_req_ready), 32'd0);
    chk("t6_stall_rst", 32'(f_stall_cnt), 32'd0);
    next_cyc();
    chk("t6_f_rsp_rst", 32'(f_rsp_valid), 32'd0);
    f_req_valid = 0;
    rst_n = 1'b1;
    next_cyc();
    chk("t6_f_rsp_after", 32'(f_rsp_valid), 32'd0);
    chk("t6_l_rsp_after", 32'(l_rsp_valid), 32'd0);

    // stall counter saturation under a long lock
    f_req_valid = 1; l_lock = 1;
    repeat (65540) next_cyc();
    chk("t6_stall_sat", 32'(f_stall_cnt), 32'hFFFF);
    repeat (4) next_cyc();
    chk("t6_stall_hold", 32'(f_stall_cnt), 32'hFFFF);
    f_req_valid = 0; l_lock = 0;
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
